full_adder: RTL and testbench



---
 rtl/full_adder.sv | 60 ++++++
 tb/tb_full_adder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/full_adder.sv
// full_adder: one-bit binary full adder with combinational sum/carry and a
// one-cycle registered copy for synchronous consumers. Ripple-carry chains
// connect carry_out of one cell to c_in of the next.
//
// Optional build macro FULL_ADDER_CHECK_EN: computes a second, arithmetic
// formulation of the addition and sets the sticky err_out flag whenever it
// disagrees with the gate-level formulation. Without the macro, err_out is
// tied to 0 and the port list is unchanged.

module full_adder (
    input  logic clk,
    input  logic rst_n,
    input  logic a_in,
    input  logic b_in,
    input  logic c_in,
    output logic sum_out,
    output logic carry_out,
    output logic sum_q,
    output logic carry_q,
    output logic valid_q,
    output logic err_out
);

    // Gate-level formulation: XOR3 for the sum, majority for the carry.
    // Neither output depends on clk or rst_n, so both stay valid during reset.
    assign sum_out   = a_in ^ b_in ^ c_in;
    assign carry_out = (a_in & b_in) | (b_in & c_in) | (a_in & c_in);

    // Registered copy of the result; valid_q marks the first post-reset capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q   <= 1'b0;
            carry_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            sum_q   <= sum_out;
            carry_q <= carry_out;
            valid_q <= 1'b1;
        end
    end

`ifdef FULL_ADDER_CHECK_EN
    logic [1:0] arith_result;

    // Independent arithmetic formulation, zero-extended so the carry is kept.
    assign arith_result = {1'b0, a_in} + {1'b0, b_in} + {1'b0, c_in};

    // Sticky error: set on any disagreement at a non-reset edge, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_out <= 1'b0;
        end else if (arith_result != {carry_out, sum_out}) begin
            err_out <= 1'b1;
        end
    end
`else
    assign err_out = 1'b0;
`endif

endmodule

// File: tb/tb_full_adder.sv
// tb_full_adder: self-checking bench for full_adder. Expected values come from
// a behavioural model (integer addition of the three input bits) plus the
// registered-stage rules; random stimulus supplements the directed scenarios.

module tb_full_adder;

    logic clk;
    logic rst_n;
    logic a_in;
    logic b_in;
    logic c_in;
    logic sum_out;
    logic carry_out;
    logic sum_q;
    logic carry_q;
    logic valid_q;
    logic err_out;

    int checks;
    int errors;

    full_adder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_in      (a_in),
        .b_in      (b_in),
        .c_in      (c_in),
        .sum_out   (sum_out),
        .carry_out (carry_out),
        .sum_q     (sum_q),
        .carry_q   (carry_q),
        .valid_q   (valid_q),
        .err_out   (err_out)
    );

    // Free-running clock, period 10, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the pair {carry, sum} is simply the integer a + b + c.
    function automatic logic [1:0] model_add(input logic a, input logic b, input logic c);
        int total;
        total = int'(a) + int'(b) + int'(c);
        return total[1:0];
    endfunction

    task automatic test_reset();
        $display("[TB] test_reset");
        @(negedge clk);
        rst_n = 1'b0;
        {a_in, b_in, c_in} = 3'b111;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({sum_q, carry_q, valid_q, err_out} !== 4'b0000) begin
                errors++;
                $display("[TB] FAIL reset_regs edge %0d: got %b expected 0000", i, {sum_q, carry_q, valid_q, err_out});
            end
            checks++;
            if ({sum_out, carry_out} !== 2'b11) begin
                errors++;
                $display("[TB] FAIL reset_comb edge %0d: got %b expected 11", i, {sum_out, carry_out});
            end
        end
    endtask

    task automatic test_sweep();
        logic [1:0] exp;
        $display("[TB] test_sweep");
        @(negedge clk);
        rst_n = 1'b1;
        for (int v = 0; v < 8; v++) begin
            {a_in, b_in, c_in} = 3'(v);
            exp = model_add(a_in, b_in, c_in);
            #1;
            checks++;
            if ({carry_out, sum_out} !== exp) begin
                errors++;
                $display("[TB] FAIL sweep_comb v=%0d: got carry,sum=%b expected %b", v, {carry_out, sum_out}, exp);
            end
            @(posedge clk);
            #1;
            checks++;
            if ({carry_q, sum_q, valid_q, err_out} !== {exp, 2'b10}) begin
                errors++;
                $display("[TB] FAIL sweep_regs v=%0d: got carry_q,sum_q,valid_q,err=%b expected %b", v, {carry_q, sum_q, valid_q, err_out}, {exp, 2'b10});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_latency();
        $display("[TB] test_latency");
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (valid_q !== 1'b0) begin
            errors++;
            $display("[TB] FAIL latency_pre valid_q: got %b expected 0", valid_q);
        end
        @(negedge clk);
        rst_n = 1'b1;
        {a_in, b_in, c_in} = 3'b011;
        @(posedge clk);
        #1;
        checks++;
        if ({sum_q, carry_q, valid_q} !== 3'b011) begin
            errors++;
            $display("[TB] FAIL latency_edgeN: got sum_q,carry_q,valid_q=%b expected 011", {sum_q, carry_q, valid_q});
        end
        @(negedge clk);
        {a_in, b_in, c_in} = 3'b100;
        @(posedge clk);
        #1;
        checks++;
        if ({sum_q, carry_q, valid_q} !== 3'b101) begin
            errors++;
            $display("[TB] FAIL latency_edgeN1: got sum_q,carry_q,valid_q=%b expected 101", {sum_q, carry_q, valid_q});
        end
    endtask

    task automatic test_glitch();
        $display("[TB] test_glitch");
        @(negedge clk);
        {a_in, b_in, c_in} = 3'b110;
        @(posedge clk);
        #1;
        checks++;
        if ({sum_q, carry_q} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL glitch_capture: got sum_q,carry_q=%b expected 01", {sum_q, carry_q});
        end
        #2;
        {a_in, b_in, c_in} = 3'b000;
        #1;
        checks++;
        if ({sum_out, carry_out} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL glitch_comb_low: got sum,carry=%b expected 00", {sum_out, carry_out});
        end
        #2;
        {a_in, b_in, c_in} = 3'b110;
        #1;
        checks++;
        if ({sum_out, carry_out} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL glitch_comb_back: got sum,carry=%b expected 01", {sum_out, carry_out});
        end
        @(posedge clk);
        #1;
        checks++;
        if ({sum_q, carry_q} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL glitch_hold: got sum_q,carry_q=%b expected 01", {sum_q, carry_q});
        end
    endtask

    task automatic test_sync_reset();
        $display("[TB] test_sync_reset");
        @(negedge clk);
        rst_n = 1'b1;
        {a_in, b_in, c_in} = 3'b111;
        @(posedge clk);
        #1;
        checks++;
        if ({sum_q, carry_q, valid_q} !== 3'b111) begin
            errors++;
            $display("[TB] FAIL sync_reset_pre: got %b expected 111", {sum_q, carry_q, valid_q});
        end
        #4;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({sum_q, carry_q, valid_q} !== 3'b111) begin
            errors++;
            $display("[TB] FAIL sync_reset_hold: got %b expected 111", {sum_q, carry_q, valid_q});
        end
        @(posedge clk);
        #1;
        checks++;
        if ({sum_q, carry_q, valid_q, err_out} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL sync_reset_clear: got %b expected 0000", {sum_q, carry_q, valid_q, err_out});
        end
        checks++;
        if ({sum_out, carry_out} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL sync_reset_comb: got %b expected 11", {sum_out, carry_out});
        end
    endtask

    task automatic test_random();
        logic [1:0] exp;
        logic [3:0] exp_regs;
        $display("[TB] test_random");
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            a_in  = 1'($urandom_range(0, 1));
            b_in  = 1'($urandom_range(0, 1));
            c_in  = 1'($urandom_range(0, 1));
            rst_n = ($urandom_range(0, 7) != 0);
            exp = model_add(a_in, b_in, c_in);
            exp_regs = rst_n ? {exp, 2'b10} : 4'b0000;
            #1;
            checks++;
            if ({carry_out, sum_out} !== exp) begin
                errors++;
                $display("[TB] FAIL random_comb n=%0d: got carry,sum=%b expected %b", n, {carry_out, sum_out}, exp);
            end
            @(posedge clk);
            #1;
            checks++;
            if ({carry_q, sum_q, valid_q, err_out} !== exp_regs) begin
                errors++;
                $display("[TB] FAIL random_regs n=%0d rst_n=%b: got %b expected %b", n, rst_n, {carry_q, sum_q, valid_q, err_out}, exp_regs);
            end
        end
    endtask

    // Runs every scenario in order, then prints the single summary line.
    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        a_in   = 1'b0;
        b_in   = 1'b0;
        c_in   = 1'b0;
        test_reset();
        test_sweep();
        test_latency();
        test_glitch();
        test_sync_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
